button_conditioner: RTL and testbench

- Conditions the five raw board pushbuttons (s/u/l/d/r) before they reach the game controller, on the 100 MHz main clock.
- Synchronises, debounces and edge-detects each button, and adds hold-to-repeat on the four direction buttons.
- Arbitrates so that at most one single-cycle command pulse is issued per clock.
- Output pulses drive the cursor-move and place-mark inputs of the game manager directly.

---
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions the five raw pushbuttons: 2-flop sync, counter debounce, rising-edge
// press detection, hold-to-repeat on directions, and fixed-priority single-pulse output.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 20000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk_bc,
  input  logic       rst_bc,
  input  logic       btns_bc,
  input  logic       btnu_bc,
  input  logic       btnd_bc,
  input  logic       btnl_bc,
  input  logic       btnr_bc,
  input  logic       move_en_bc,
  output logic       s_pulse_bc,
  output logic       u_pulse_bc,
  output logic       d_pulse_bc,
  output logic       l_pulse_bc,
  output logic       r_pulse_bc,
  output logic [4:0] held_bc
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_RATE  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Bit order everywhere is {s,u,d,l,r}; bits 3..0 are the direction buttons.
  logic [4:0] raw;
  logic [4:0] sync1_q, sync1_d;
  logic [4:0] sync2_q, sync2_d;
  logic [4:0] stable_q, stable_d;
  logic [4:0] stable_prev_q, stable_prev_d;
  logic [4:0] pulse_q, pulse_d;
  logic [3:0] rep_phase_q, rep_phase_d;
  logic [CNT_W-1:0] db_cnt_q [5];
  logic [CNT_W-1:0] db_cnt_d [5];
  logic [CNT_W-1:0] rep_cnt_q [4];
  logic [CNT_W-1:0] rep_cnt_d [4];

  logic [4:0] press_req;
  logic [3:0] rep_req;
  logic [4:0] req;

  assign raw = {btns_bc, btnu_bc, btnd_bc, btnl_bc, btnr_bc};

  always_comb begin
    sync1_d       = raw;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign press_req = stable_q & ~stable_prev_q;

  // Phase 0 waits REPEAT_DELAY after the press, phase 1 fires every REPEAT_RATE.
  always_comb begin
    rep_req     = '0;
    rep_phase_d = rep_phase_q;
    for (int i = 0; i < 4; i++) begin
      rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
      if (!stable_q[i] || !move_en_bc) begin
        rep_cnt_d[i]   = '0;
        rep_phase_d[i] = 1'b0;
      end else if (press_req[i]) begin
        rep_cnt_d[i]   = CNT_ONE;
        rep_phase_d[i] = 1'b0;
      end else if (rep_cnt_q[i] == (rep_phase_q[i] ? REP_RATE : REP_DELAY)) begin
        rep_req[i]     = 1'b1;
        rep_cnt_d[i]   = CNT_ONE;
        rep_phase_d[i] = 1'b1;
      end
    end
  end

  assign req = {press_req[4], {4{move_en_bc}} & (press_req[3:0] | rep_req)};

  // Losing requests are simply dropped this cycle.
  always_comb begin
    pulse_d = '0;
    if (req[4])      pulse_d = 5'b10000;
    else if (req[3]) pulse_d = 5'b01000;
    else if (req[2]) pulse_d = 5'b00100;
    else if (req[1]) pulse_d = 5'b00010;
    else if (req[0]) pulse_d = 5'b00001;
  end

  always_ff @(posedge clk_bc) begin
    if (!rst_bc) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      pulse_q       <= '0;
      rep_phase_q   <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      pulse_q       <= pulse_d;
      rep_phase_q   <= rep_phase_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end

  assign {s_pulse_bc, u_pulse_bc, d_pulse_bc, l_pulse_bc, r_pulse_bc} = pulse_q;
  assign held_bc = stable_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat constants;
// expected pulse timings are hand-computed per step.
module tb_button_conditioner;

  logic clk_bc = 1'b0;
  always #5 clk_bc = ~clk_bc;

  logic       rst_bc, move_en_bc;
  logic       btns_bc, btnu_bc, btnd_bc, btnl_bc, btnr_bc;
  logic       s_pulse_bc, u_pulse_bc, d_pulse_bc, l_pulse_bc, r_pulse_bc;
  logic [4:0] held_bc;
  logic [4:0] pulses;

  int checks = 0;
  int errors = 0;

  assign pulses = {s_pulse_bc, u_pulse_bc, d_pulse_bc, l_pulse_bc, r_pulse_bc};

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(5),
    .CNT_W(8)
  ) dut (
    .clk_bc(clk_bc),
    .rst_bc(rst_bc),
    .btns_bc(btns_bc),
    .btnu_bc(btnu_bc),
    .btnd_bc(btnd_bc),
    .btnl_bc(btnl_bc),
    .btnr_bc(btnr_bc),
    .move_en_bc(move_en_bc),
    .s_pulse_bc(s_pulse_bc),
    .u_pulse_bc(u_pulse_bc),
    .d_pulse_bc(d_pulse_bc),
    .l_pulse_bc(l_pulse_bc),
    .r_pulse_bc(r_pulse_bc),
    .held_bc(held_bc)
  );

  task automatic tick();
    @(posedge clk_bc);
    #1;
  endtask

  task automatic chk_p(input logic [4:0] exp, input string tag);
    checks++;
    assert (pulses === exp) else begin
      errors++;
      $error("FAIL %s pulses=%b expected=%b", tag, pulses, exp);
    end
  endtask

  task automatic chk_h(input logic [4:0] exp, input string tag);
    checks++;
    assert (held_bc === exp) else begin
      errors++;
      $error("FAIL %s held=%b expected=%b", tag, held_bc, exp);
    end
  endtask

  task automatic chk_n(input int obs, input int exp, input string tag);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s count=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_p(5'b00000, tag);
    end
  endtask

  initial begin
    int cnt;
    rst_bc = 1'b0; move_en_bc = 1'b1;
    btns_bc = 1'b1; btnu_bc = 1'b0; btnd_bc = 1'b0; btnl_bc = 1'b0; btnr_bc = 1'b0;

    // 1: reset with centre held, then press seen after 2 sync + 4 debounce cycles
    repeat (3) begin
      tick();
      chk_p(5'b00000, "rst_pulse");
      chk_h(5'b00000, "rst_held");
    end
    rst_bc = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk_h((t >= 6) ? 5'b10000 : 5'b00000, "t1_held");
      chk_p((t == 7) ? 5'b10000 : 5'b00000, "t1_pulse");
    end
    btns_bc = 1'b0;
    quiet(12, "t1_release");
    chk_h(5'b00000, "t1_held_low");

    // 2: 3-cycle glitch rejected, 4-cycle press accepted
    btnl_bc = 1'b1;
    quiet(3, "t2_glitch");
    btnl_bc = 1'b0;
    quiet(12, "t2_glitch_after");
    chk_h(5'b00000, "t2_glitch_held");
    for (int t = 1; t <= 20; t++) begin
      btnl_bc = (t <= 4);
      tick();
      if (t == 6) chk_h(5'b00010, "t2_held");
      if (t == 15) chk_h(5'b00000, "t2_held_low");
      chk_p((t == 7) ? 5'b00010 : 5'b00000, "t2_pulse");
    end

    // 3: right held 34 raw cycles -> press plus five repeats, nothing after release
    cnt = 0;
    for (int t = 1; t <= 50; t++) begin
      btnr_bc = (t <= 34);
      tick();
      if (r_pulse_bc === 1'b1) cnt++;
      chk_p((t == 7 || t == 17 || t == 22 || t == 27 || t == 32 || t == 37)
            ? 5'b00001 : 5'b00000, "t3_repeat");
    end
    chk_n(cnt, 6, "t3_count");

    // 4: centre held 40 cycles never repeats
    cnt = 0;
    for (int t = 1; t <= 50; t++) begin
      btns_bc = (t <= 40);
      tick();
      if (s_pulse_bc === 1'b1) cnt++;
      chk_p((t == 7) ? 5'b10000 : 5'b00000, "t4_centre");
    end
    chk_n(cnt, 1, "t4_count");

    // 5: simultaneous s and u press: s wins, u only appears at its repeat points
    for (int t = 1; t <= 40; t++) begin
      btns_bc = (t <= 20);
      btnu_bc = (t <= 25);
      tick();
      if (t == 6) chk_h(5'b11000, "t5_held");
      if (t == 7) chk_p(5'b10000, "t5_arb");
      else chk_p((t == 17 || t == 22 || t == 27) ? 5'b01000 : 5'b00000, "t5_pulse");
    end

    // 6: gated down press, enable mid-hold, then reset mid-hold
    move_en_bc = 1'b0;
    btnd_bc = 1'b1;
    quiet(20, "t6_gated");
    chk_h(5'b00100, "t6_held");
    move_en_bc = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk_p((t == 11) ? 5'b00100 : 5'b00000, "t6_enable");
    end
    rst_bc = 1'b0;
    tick();
    chk_p(5'b00000, "t6_rst_pulse");
    chk_h(5'b00000, "t6_rst_held");
    rst_bc = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk_h((t >= 6) ? 5'b00100 : 5'b00000, "t6_after_rst_held");
      chk_p((t == 7) ? 5'b00100 : 5'b00000, "t6_after_rst_pulse");
    end
    btnd_bc = 1'b0;
    quiet(12, "t6_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
